wire_delay: RTL and testbench

WIRE_DELAY -- requirements
Module: wire_delay

---
 rtl/wire_delay.sv | 150 +++++++++++++++
 tb/tb_wire_delay.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/wire_delay.sv
// Bidirectional pin delay model: senses which side drives, forwards it
// to the other side through a per-direction delay line.
//   i_clk           sampling clock for the detector and the delay lines
//   i_nrst          asynchronous active-low reset
//   io_a            controller-side pin
//   io_b            memory-side pin
//   i_phy_init_done calibration done; gates read-data inversion
module wire_delay #(
   parameter int    DELAY_G    = 0,
   parameter int    DELAY_RD   = 0,
   parameter string ERR_INSERT = "OFF"
) (
   input  logic i_clk,
   input  logic i_nrst,
   inout  wire  io_a,
   inout  wire  io_b,
   input  logic i_phy_init_done
);

   typedef enum logic [1:0] {
      IDLE,
      A2B,
      B2A
   } dir_t;

   localparam logic ERR_ON = (ERR_INSERT == "ON");

   dir_t state;
   dir_t nxt;
   logic a_q;
   logic b_q;
   logic res_a;
   logic res_b;
   logic z_a;
   logic z_b;
   logic chg_a;
   logic chg_b;
   logic drv_z;
   logic z_seen;
   logic oe_a;
   logic oe_b;
   logic wr_out;
   logic rd_out;
   logic rd_dat;

   // X and Z both resolve to 0
   assign res_a = (io_a === 1'b1);
   assign res_b = (io_b === 1'b1);
   assign z_a   = (io_a === 1'bz);
   assign z_b   = (io_b === 1'bz);

   // a pin we drive ourselves never counts as an external change
   assign chg_a = (state != B2A) && !z_a && (res_a != a_q);
   assign chg_b = (state != A2B) && !z_b && (res_b != b_q);

   // the external driver has let go of its pin
   assign drv_z = (state == A2B) ? z_a :
                  (state == B2A) ? z_b : 1'b0;

   always_comb begin
      nxt = state;
      if (chg_a)
         nxt = A2B;
      else if (chg_b)
         nxt = B2A;
      else if (drv_z && z_seen)
         nxt = IDLE;
   end

   // Output enables follow the new state at the detecting edge,
   // so the takeover costs no extra cycle.
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         state  <= IDLE;
         z_seen <= 1'b0;
         oe_a   <= 1'b0;
         oe_b   <= 1'b0;
         a_q    <= 1'b0;
         b_q    <= 1'b0;
      end else begin
         state  <= nxt;
         z_seen <= drv_z && (nxt == state);
         oe_a   <= (nxt == B2A);
         oe_b   <= (nxt == A2B);
         a_q    <= res_a;
         b_q    <= res_b;
      end
   end

   // Delay lines always shift; a valid mask restarts on entry into
   // the direction so older samples are replaced by 0 until refilled.
   if (DELAY_G == 0) begin : g_wr0
      assign wr_out = res_a;
   end else begin : g_wr
      logic [DELAY_G-1:0] pipe;
      logic [DELAY_G-1:0] vld;
      logic               ent;

      assign ent = (nxt == A2B) && (state != A2B);

      always_ff @(posedge i_clk or negedge i_nrst) begin
         if (!i_nrst) begin
            pipe <= '0;
            vld  <= '0;
         end else begin
            pipe[0] <= res_a;
            vld[0]  <= 1'b1;
            for (int i = 1; i < DELAY_G; i++) begin
               pipe[i] <= pipe[i-1];
               vld[i]  <= vld[i-1] && !ent;
            end
         end
      end

      assign wr_out = vld[DELAY_G-1] & pipe[DELAY_G-1];
   end

   if (DELAY_RD == 0) begin : g_rd0
      assign rd_out = res_b;
   end else begin : g_rd
      logic [DELAY_RD-1:0] pipe;
      logic [DELAY_RD-1:0] vld;
      logic                ent;

      assign ent = (nxt == B2A) && (state != B2A);

      always_ff @(posedge i_clk or negedge i_nrst) begin
         if (!i_nrst) begin
            pipe <= '0;
            vld  <= '0;
         end else begin
            pipe[0] <= res_b;
            vld[0]  <= 1'b1;
            for (int i = 1; i < DELAY_RD; i++) begin
               pipe[i] <= pipe[i-1];
               vld[i]  <= vld[i-1] && !ent;
            end
         end
      end

      assign rd_out = vld[DELAY_RD-1] & pipe[DELAY_RD-1];
   end

   // only the read direction is ever corrupted
   assign rd_dat = rd_out ^ (ERR_ON & i_phy_init_done);

   assign io_a = oe_a ? rd_dat : 1'bz;
   assign io_b = oe_b ? wr_out : 1'bz;

endmodule

// File: tb/tb_wire_delay.sv
// Directed bench for wire_delay: three instances cover the default
// pass-through, a 3-cycle read delay and read-data error insertion.
module tb_wire_delay;

   logic clk = 1'b0;
   logic nrst = 1'b0;
   logic init2 = 1'b1;

   logic a0_en = 1'b0, a0_v = 1'b0, b0_en = 1'b0, b0_v = 1'b0;
   logic a1_en = 1'b0, a1_v = 1'b0, b1_en = 1'b0, b1_v = 1'b0;
   logic a2_en = 1'b0, a2_v = 1'b0, b2_en = 1'b0, b2_v = 1'b0;

   wire a0, b0, a1, b1, a2, b2;

   assign a0 = a0_en ? a0_v : 1'bz;
   assign b0 = b0_en ? b0_v : 1'bz;
   assign a1 = a1_en ? a1_v : 1'bz;
   assign b1 = b1_en ? b1_v : 1'bz;
   assign a2 = a2_en ? a2_v : 1'bz;
   assign b2 = b2_en ? b2_v : 1'bz;

   // pin observation: 2 = high-Z, otherwise the 0/1 level
   wire [1:0] a0_e = (a0 === 1'bz) ? 2'd2 : {1'b0, a0};
   wire [1:0] b0_e = (b0 === 1'bz) ? 2'd2 : {1'b0, b0};
   wire [1:0] a1_e = (a1 === 1'bz) ? 2'd2 : {1'b0, a1};
   wire [1:0] a2_e = (a2 === 1'bz) ? 2'd2 : {1'b0, a2};
   wire [1:0] b2_e = (b2 === 1'bz) ? 2'd2 : {1'b0, b2};

   always #5 clk = ~clk;

   wire_delay u0 (
      .i_clk          (clk),
      .i_nrst         (nrst),
      .io_a           (a0),
      .io_b           (b0),
      .i_phy_init_done(1'b0)
   );

   wire_delay #(.DELAY_RD(3)) u1 (
      .i_clk          (clk),
      .i_nrst         (nrst),
      .io_a           (a1),
      .io_b           (b1),
      .i_phy_init_done(1'b0)
   );

   wire_delay #(.ERR_INSERT("ON")) u2 (
      .i_clk          (clk),
      .i_nrst         (nrst),
      .io_a           (a2),
      .io_b           (b2),
      .i_phy_init_done(init2)
   );

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   initial begin
      #2;
      a0_en = 1'b1;
      a0_v  = 1'b1;
      #1;
      chk("rst_b0_z", int'(b0_e), 2);
      chk("rst_a1_z", int'(a1_e), 2);
      chk("rst_b2_z", int'(b2_e), 2);
      step();
      step();
      chk("rst_hold_b0_z", int'(b0_e), 2);

      // write direction, zero delay
      nrst = 1'b1;
      step();
      chk("a2b_same_cycle", int'(b0_e), 1);
      a0_v = 1'b0;
      #1;
      chk("a2b_pass0", int'(b0_e), 0);
      a0_v = 1'b1;
      #1;
      chk("a2b_pass1", int'(b0_e), 1);

      // release: one Z cycle keeps driving, two return to IDLE
      a0_en = 1'b0;
      step();
      chk("rel1_still_drv", int'(b0_e), 0);
      step();
      chk("rel2_idle", int'(b0_e), 2);

      // X resolves to 0
      a0_en = 1'b1;
      a0_v  = 1'b1;
      step();
      chk("x_pre", int'(b0_e), 1);
      a0_v = 1'bx;
      #1;
      chk("x_resolved", int'(b0_e), 0);
      a0_en = 1'b0;
      step();
      step();
      chk("x_idle", int'(b0_e), 2);

      // simultaneous change: controller wins
      a0_en = 1'b1;
      a0_v  = 1'b1;
      b0_en = 1'b1;
      b0_v  = 1'b1;
      step();
      b0_en = 1'b0;
      #1;
      chk("both_a2b", int'(b0_e), 1);
      a0_v = 1'b0;
      #1;
      chk("both_follow", int'(b0_e), 0);
      a0_en = 1'b0;
      step();
      step();
      chk("both_idle", int'(b0_e), 2);

      // read direction, 3-cycle delay
      b1_en = 1'b1;
      b1_v  = 1'b1;
      #1;
      chk("rd_pre_z", int'(a1_e), 2);
      step();
      chk("rd_c1", int'(a1_e), 0);
      step();
      chk("rd_c2", int'(a1_e), 0);
      step();
      chk("rd_c3", int'(a1_e), 1);
      step();
      chk("rd_c4", int'(a1_e), 1);

      // error insertion on the read path only
      b2_en = 1'b1;
      b2_v  = 1'b1;
      step();
      chk("err_inv1", int'(a2_e), 0);
      b2_v = 1'b0;
      #1;
      chk("err_inv0", int'(a2_e), 1);
      init2 = 1'b0;
      #1;
      chk("err_gated0", int'(a2_e), 0);
      b2_v = 1'b1;
      #1;
      chk("err_gated1", int'(a2_e), 1);
      b2_en = 1'b0;
      step();
      step();
      chk("err_idle", int'(a2_e), 2);
      a2_en = 1'b1;
      a2_v  = 1'b1;
      init2 = 1'b1;
      step();
      chk("err_a2b_clean1", int'(b2_e), 1);
      a2_v = 1'b0;
      #1;
      chk("err_a2b_clean0", int'(b2_e), 0);
      a2_en = 1'b0;

      // asynchronous reset during B2A
      #1;
      nrst = 1'b0;
      #1;
      chk("rst_async_a1_z", int'(a1_e), 2);
      b1_v = 1'b0;
      step();
      nrst = 1'b1;
      step();
      step();
      chk("post_rst_idle", int'(a1_e), 2);
      b1_v = 1'b1;
      step();
      chk("post_rst_refill", int'(a1_e), 0);
      step();
      step();
      chk("post_rst_data", int'(a1_e), 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
